// File: rtl/ppu_vram_seq_pkg.sv
// Shared definitions for the PPU VRAM bus sequencer.
//   state_e : bus cycle phase encoding
//   ADDR_W  : VRAM address width
//   DATA_W  : VRAM data width
//   INC_1 / INC_32 : post-access increments of the CPU address counter
package ppu_vram_seq_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] INC_1  = 14'd1;
  localparam logic [ADDR_W-1:0] INC_32 = 14'd32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ALE  = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } state_e;

endpackage

// File: rtl/ppu_vram_addr_ctr.sv
// CPU-visible VRAM address counter.
//   clk_i, rst_n_i : clock, async active-low reset
//   load_i, load_addr_i : load a new counter value (beats the increment)
//   inc_i, inc32_i : advance by 32 when inc32_i, otherwise by 1
//   vaddr_o : current counter value; wraps modulo 2^14
module ppu_vram_addr_ctr
  import ppu_vram_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              inc_i,
  input  logic              inc32_i,
  output logic [ADDR_W-1:0] vaddr_o
);

  logic [ADDR_W-1:0] vaddr_q;
  logic [ADDR_W-1:0] vaddr_d;

  always_comb begin
    vaddr_d = vaddr_q;
    if (load_i) begin
      vaddr_d = load_addr_i;
    end else if (inc_i) begin
      // 14-bit add wraps naturally at the top of VRAM space
      vaddr_d = vaddr_q + (inc32_i ? INC_32 : INC_1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vaddr_q <= '0;
    end else begin
      vaddr_q <= vaddr_d;
    end
  end

  assign vaddr_o = vaddr_q;

endmodule

// File: rtl/ppu_vram_seq.sv
// PPU VRAM bus sequencer: arbitrates rendering fetches against CPU $2007
// accesses and runs the two-phase ALE / strobe bus cycle toward the pads.
//   PCLK, n_RES            : clock, async active-low reset
//   fetch_req/addr/done/data : rendering fetch port
//   cpu_rd_req/wr_req/wdata : $2007 access pulses
//   addr_load/addr_in/inc32/vaddr : CPU VRAM address counter
//   rd_buf, cpu_busy       : $2007 read buffer and access-in-progress flag
//   n_ALE_topad, n_PA, RD_topad, WR_topad, PD_out, pd_wdata, pd_drive : pad side
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no bus cycle in progress, bus outputs held
// ALE     | address phase, n_ALE_topad low, n_PA driven
// RD      | read strobe phase, PD_out captured at its end
// WR      | write strobe phase, write data driven onto AD
module ppu_vram_seq
  import ppu_vram_seq_pkg::*;
(
  input  logic              PCLK,
  input  logic              n_RES,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_done,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              cpu_rd_req,
  input  logic              cpu_wr_req,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              inc32,
  output logic [ADDR_W-1:0] vaddr,
  output logic [DATA_W-1:0] rd_buf,
  output logic              cpu_busy,
  output logic              n_ALE_topad,
  output logic [ADDR_W-1:0] n_PA,
  output logic              RD_topad,
  output logic              WR_topad,
  input  logic [DATA_W-1:0] PD_out,
  output logic [DATA_W-1:0] pd_wdata,
  output logic              pd_drive
);

  state_e            state_q;
  logic              fetch_req_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic              cpu_pending_q;
  logic              cpu_wr_q;
  logic [DATA_W-1:0] cpu_wdata_q;
  logic              gnt_cpu_q;     // bus cycle in flight belongs to the CPU
  logic              n_ale_q;
  logic [ADDR_W-1:0] n_pa_q;
  logic              rd_q;
  logic              wr_q;
  logic              pd_drive_q;
  logic [DATA_W-1:0] pd_wdata_q;
  logic              fetch_done_q;
  logic [DATA_W-1:0] fetch_data_q;
  logic [DATA_W-1:0] rd_buf_q;

  logic strobe_end;
  logic cpu_done;
  logic grant_fetch;
  logic grant_cpu;
  logic grant_any;

  always_comb begin
    strobe_end  = (state_q == ST_RD) || (state_q == ST_WR);
    cpu_done    = strobe_end && gnt_cpu_q;
    grant_fetch = fetch_req_q;
    // the CPU access finishing this edge is still flagged pending; don't regrant it
    grant_cpu   = !fetch_req_q && cpu_pending_q && !cpu_done;
    grant_any   = ((state_q == ST_IDLE) || strobe_end) && (grant_fetch || grant_cpu);
  end

  // Request capture. cpu_busy mirrors cpu_pending_q, so anything arriving
  // while an access is pending or in flight is dropped here.
  always_ff @(posedge PCLK or negedge n_RES) begin
    if (!n_RES) begin
      fetch_req_q   <= 1'b0;
      fetch_addr_q  <= '0;
      cpu_pending_q <= 1'b0;
      cpu_wr_q      <= 1'b0;
      cpu_wdata_q   <= '0;
    end else begin
      fetch_req_q  <= fetch_req;
      fetch_addr_q <= fetch_addr;
      if (cpu_done) begin
        cpu_pending_q <= 1'b0;
      end else if (!cpu_pending_q && (cpu_rd_req || cpu_wr_req)) begin
        cpu_pending_q <= 1'b1;
        cpu_wr_q      <= cpu_wr_req;
        if (cpu_wr_req) begin
          cpu_wdata_q <= cpu_wdata;
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge n_RES) begin
    if (!n_RES) begin
      state_q      <= ST_IDLE;
      gnt_cpu_q    <= 1'b0;
      n_ale_q      <= 1'b1;
      n_pa_q       <= '1;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      pd_drive_q   <= 1'b0;
      pd_wdata_q   <= '0;
      fetch_done_q <= 1'b0;
      fetch_data_q <= '0;
      rd_buf_q     <= '0;
    end else begin
      fetch_done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RD, ST_WR: begin
          if (state_q == ST_RD) begin
            if (gnt_cpu_q) begin
              rd_buf_q <= PD_out;
            end else begin
              fetch_data_q <= PD_out;
              fetch_done_q <= 1'b1;
            end
          end
          rd_q       <= 1'b0;
          wr_q       <= 1'b0;
          pd_drive_q <= 1'b0;
          if (grant_any) begin
            state_q   <= ST_ALE;
            n_ale_q   <= 1'b0;
            gnt_cpu_q <= !grant_fetch;
            if (grant_fetch) begin
              n_pa_q <= ~fetch_addr_q;
            end else begin
              n_pa_q <= ~vaddr;
              if (cpu_wr_q) begin
                pd_wdata_q <= cpu_wdata_q;
              end
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ALE: begin
          n_ale_q <= 1'b1;
          if (gnt_cpu_q && cpu_wr_q) begin
            state_q    <= ST_WR;
            wr_q       <= 1'b1;
            pd_drive_q <= 1'b1;
          end else begin
            state_q <= ST_RD;
            rd_q    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ppu_vram_addr_ctr u_addr_ctr (
    .clk_i       (PCLK),
    .rst_n_i     (n_RES),
    .load_i      (addr_load),
    .load_addr_i (addr_in),
    .inc_i       (cpu_done),
    .inc32_i     (inc32),
    .vaddr_o     (vaddr)
  );

  assign fetch_done  = fetch_done_q;
  assign fetch_data  = fetch_data_q;
  assign rd_buf      = rd_buf_q;
  assign cpu_busy    = cpu_pending_q;
  assign n_ALE_topad = n_ale_q;
  assign n_PA        = n_pa_q;
  assign RD_topad    = rd_q;
  assign WR_topad    = wr_q;
  assign pd_wdata    = pd_wdata_q;
  assign pd_drive    = pd_drive_q;

endmodule
